// File: rtl/deco_pipe.sv
// Pipelined instruction decoder: an input FIFO feeds one decode stage that folds
// immediate-prefix words into the next instruction and drives a registered record.
module deco_pipe #(
  parameter int FIFO_DEPTH = 4,
  parameter int TA_W       = 6,
  parameter int IMM_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_op,
  output logic [3:0]       out_funct,
  output logic             out_immab,
  output logic [IMM_W-1:0] out_imm,
  output logic             out_has_pfx,
  output logic [9:0]       out_offset,
  output logic [6:0]       out_nalloc,
  output logic             out_end,
  output logic [TA_W-1:0]  out_ta1,
  output logic [TA_W-1:0]  out_ta2,
  output logic [1:0]       out_tt1,
  output logic [1:0]       out_tt2,
  output logic             err_pfx
);
  localparam int AW = $clog2(FIFO_DEPTH);

  function automatic logic [IMM_W-1:0] sext6(input logic [5:0] v);
    return {{(IMM_W-6){v[5]}}, v};
  endfunction

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             r_pfx_val, r_out_valid, r_err;
  logic [25:0]      r_pfx_hi;
  logic [2:0]       r_op;
  logic [3:0]       r_funct;
  logic             r_immab, r_has_pfx, r_end;
  logic [IMM_W-1:0] r_imm;
  logic [9:0]       r_offset;
  logic [6:0]       r_nalloc;
  logic [TA_W-1:0]  r_ta1, r_ta2;
  logic [1:0]       r_tt1, r_tt2;

  logic             w_full, w_empty, w_push, w_pop;
  logic [31:0]      w_instr;
  logic [2:0]       w_op;
  logic             w_is_pfx, w_noimm, w_rr, w_has_funct, w_has_ab;
  logic [IMM_W-1:0] w_imm;
  logic [TA_W-1:0]  w_ta1, w_ta2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty  = (r_wptr == r_rptr);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full && !flush;
  assign w_pop    = !w_empty && (!r_out_valid || out_ready) && !flush;

  assign w_instr     = r_mem[r_rptr[AW-1:0]];
  assign w_op        = w_instr[31:29];
  assign w_is_pfx    = (w_op == 3'b100);
  assign w_noimm     = (w_op == 3'b101) || (w_op == 3'b011);
  assign w_rr        = (w_op == 3'b000) || (w_op == 3'b001) || (w_op == 3'b011);
  assign w_has_ab    = (w_op == 3'b000) || (w_op == 3'b001) || (w_op == 3'b010);
  assign w_has_funct = !w_op[2] && (w_op != 3'b011);

  always_comb begin
    w_imm = '0;
    if (!w_noimm) begin
      if (r_pfx_val) w_imm[31:0] = {r_pfx_hi, w_instr[23:18]};
      else           w_imm = sext6(w_instr[23:18]);
    end
  end

  always_comb begin
    w_ta1 = '0;
    w_ta2 = '0;
    if (w_rr) begin
      w_ta1[5:0] = w_instr[13:8];
      w_ta2[5:0] = w_instr[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_instr;
  end

  // Control: pointers, pending prefix, record valid and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_pfx_val   <= 1'b0;
      r_pfx_hi    <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_pop && r_pfx_val && (w_is_pfx || w_noimm);
      if (flush) begin
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_pfx_val   <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
        if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        if (w_pop && w_is_pfx) begin
          r_pfx_val <= 1'b1;
          r_pfx_hi  <= w_instr[25:0];
        end else if (w_pop) begin
          r_pfx_val <= 1'b0;
        end
        if (w_pop && !w_is_pfx) r_out_valid <= 1'b1;
        else if (out_ready)     r_out_valid <= 1'b0;
      end
    end
  end

  // Decode stage boundary: record fields load only on a non-prefix pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_funct   <= '0;
      r_immab   <= 1'b0;
      r_imm     <= '0;
      r_has_pfx <= 1'b0;
      r_offset  <= '0;
      r_nalloc  <= '0;
      r_end     <= 1'b0;
      r_ta1     <= '0;
      r_ta2     <= '0;
      r_tt1     <= '0;
      r_tt2     <= '0;
    end else if (w_pop && !w_is_pfx) begin
      r_op      <= w_op;
      r_funct   <= w_has_funct ? w_instr[28:25] : 4'd0;
      r_immab   <= w_has_ab && w_instr[24];
      r_imm     <= w_imm;
      r_has_pfx <= r_pfx_val;
      r_offset  <= (w_op == 3'b010) ? w_instr[9:0] : 10'd0;
      r_nalloc  <= (w_op == 3'b101) ? w_instr[6:0] : 7'd0;
      r_end     <= (w_op == 3'b101) && w_instr[28];
      r_ta1     <= w_ta1;
      r_ta2     <= w_ta2;
      r_tt1     <= w_rr ? w_instr[15:14] : 2'd0;
      r_tt2     <= w_rr ? w_instr[7:6] : 2'd0;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_op      = r_op;
  assign out_funct   = r_funct;
  assign out_immab   = r_immab;
  assign out_imm     = r_imm;
  assign out_has_pfx = r_has_pfx;
  assign out_offset  = r_offset;
  assign out_nalloc  = r_nalloc;
  assign out_end     = r_end;
  assign out_ta1     = r_ta1;
  assign out_ta2     = r_ta2;
  assign out_tt1     = r_tt1;
  assign out_tt2     = r_tt2;
  assign err_pfx     = r_err;
endmodule

// File: tb/tb_deco_pipe.sv
// Directed bench for deco_pipe: plain decode, prefix folding, back-pressure,
// flush and asynchronous reset, with hand-computed expected records.
module tb_deco_pipe;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [2:0]  out_op;
  logic [3:0]  out_funct;
  logic        out_immab, out_has_pfx, out_end, err_pfx;
  logic [31:0] out_imm;
  logic [9:0]  out_offset;
  logic [6:0]  out_nalloc;
  logic [5:0]  out_ta1, out_ta2;
  logic [1:0]  out_tt1, out_tt2;

  int checks = 0;
  int errors = 0;
  int n_acc, rec_n, err_n;
  logic [5:0]  seq [16];
  logic [2:0]  l_op;
  logic [3:0]  l_funct;
  logic [31:0] l_imm;
  logic        l_has, l_end;
  logic [6:0]  l_nalloc;
  logic [9:0]  l_offset;

  localparam logic [31:0] T1 = 32'b000_0001_0_010101_00_10_101010_11_111100;
  localparam logic [31:0] P2 = 32'b100_000_10101010101010101010101010;
  localparam logic [31:0] W2 = 32'b010_0011_0_010101_00000000_1011001110;
  localparam logic [31:0] W3 = 32'b101_0_000000000000000000000_1110011;
  localparam logic [31:0] Y  = {3'b001, 4'h5, 1'b1, 6'b110000, 18'h0};

  deco_pipe #(.FIFO_DEPTH(4), .TA_W(6), .IMM_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_funct(out_funct), .out_immab(out_immab),
    .out_imm(out_imm), .out_has_pfx(out_has_pfx), .out_offset(out_offset),
    .out_nalloc(out_nalloc), .out_end(out_end),
    .out_ta1(out_ta1), .out_ta2(out_ta2), .out_tt1(out_tt1), .out_tt2(out_tt2),
    .err_pfx(err_pfx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, log any record handed over at this edge, advance.
  task automatic cyc(input logic v, input logic [31:0] w);
    in_valid = v;
    in_instr = w;
    if (v && in_ready) n_acc++;
    if (out_valid && out_ready) begin
      if (rec_n < 16) seq[rec_n] = out_ta2;
      rec_n++;
      l_op = out_op; l_funct = out_funct; l_imm = out_imm; l_has = out_has_pfx;
      l_end = out_end; l_nalloc = out_nalloc; l_offset = out_offset;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    err_n += int'(err_pfx);
  endtask

  task automatic clr();
    n_acc = 0; rec_n = 0; err_n = 0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    clr();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err_pfx, 0);
    chk("rst_imm", out_imm, 0);

    // Plain decode, record two edges after the push.
    out_ready = 1'b1;
    cyc(1, T1);
    chk("t1_not_yet", out_valid, 0);
    cyc(0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_op", out_op, 0);
    chk("t1_funct", out_funct, 1);
    chk("t1_immab", out_immab, 0);
    chk("t1_imm", out_imm, 32'h15);
    chk("t1_tt1", out_tt1, 2);
    chk("t1_ta1", out_ta1, 42);
    chk("t1_tt2", out_tt2, 3);
    chk("t1_ta2", out_ta2, 60);
    chk("t1_haspfx", out_has_pfx, 0);
    chk("t1_offset", out_offset, 0);
    cyc(0, 0);
    chk("t1_drained", out_valid, 0);

    // Prefix merge.
    clr();
    cyc(1, P2); cyc(1, W2);
    repeat (4) cyc(0, 0);
    chk("t2_nrec", rec_n, 1);
    chk("t2_op", l_op, 2);
    chk("t2_funct", l_funct, 3);
    chk("t2_imm", l_imm, {26'h2AAAAAA, 6'b010101});
    chk("t2_haspfx", l_has, 1);
    chk("t2_offset", l_offset, 10'h2CE);
    chk("t2_err", err_n, 0);

    // Double prefix into a no-immediate consumer.
    clr();
    cyc(1, P2); cyc(1, P2); cyc(1, W3);
    repeat (4) cyc(0, 0);
    chk("t3_err_pulses", err_n, 2);
    chk("t3_nrec", rec_n, 1);
    chk("t3_op", l_op, 5);
    chk("t3_funct", l_funct, 0);
    chk("t3_nalloc", l_nalloc, 7'h73);
    chk("t3_end", l_end, 0);
    chk("t3_imm", l_imm, 0);
    chk("t3_haspfx", l_has, 1);

    // Back-pressure: FIFO_DEPTH buffered plus one in the output register.
    clr();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) cyc(1, {3'b001, 23'h0, 6'(i + 1)});
    chk("bp_accepted", n_acc, 5);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1'b1;
    repeat (7) cyc(0, 0);
    chk("bp_nrec", rec_n, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("bp_order%0d", i), seq[i], i + 1);

    // Flush with three words buffered and a prefix pending.
    clr();
    out_ready = 1'b0;
    cyc(1, {3'b001, 29'h7}); cyc(1, P2); cyc(1, {3'b001, 29'h8});
    cyc(1, {3'b001, 29'h9}); cyc(1, {3'b001, 29'hA});
    chk("fl_full", in_ready, 0);
    out_ready = 1'b1;
    cyc(0, 0);
    chk("fl_pre_valid", out_valid, 0);
    flush = 1'b1;
    cyc(1, {3'b001, 29'hB});
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    cyc(0, 0);
    chk("fl_discard", out_valid, 0);
    cyc(1, Y); cyc(0, 0);
    chk("fl_y_valid", out_valid, 1);
    chk("fl_y_haspfx", out_has_pfx, 0);
    chk("fl_y_imm", out_imm, 32'hFFFF_FFF0);
    chk("fl_y_funct", out_funct, 5);
    chk("fl_y_immab", out_immab, 1);
    cyc(0, 0);

    // Asynchronous reset while full and stalled.
    clr();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, Y | 32'(i + 1));
    chk("ar_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_op", out_op, 0);
    chk("ar_imm", out_imm, 0);
    chk("ar_ta2", out_ta2, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_no_partial", out_valid, 0);
    out_ready = 1'b1;
    cyc(1, T1); cyc(0, 0);
    chk("ar_resume_valid", out_valid, 1);
    chk("ar_resume_ta1", out_ta1, 42);
    chk("ar_resume_imm", out_imm, 32'h15);
    cyc(0, 0);
    chk("ar_resume_once", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/deco_pipe.md
# deco_pipe

Pipelined, parametrised successor to the combinational instruction decoder. It buffers fetched 32-bit instructions in an input FIFO and folds immediate-prefix instructions (op 100) into the following instruction. It emits one registered, fully decoded record per non-prefix instruction over a valid/ready handshake. It sits between the fetch unit and the CGRA tile dispatch logic.

## Interface

Parameters:
- FIFO_DEPTH, 4: input FIFO entries; power of two, ≥2.
- TA_W, 6: target-address width; instruction fields stay 6 bits and are zero-extended to TA_W.
- IMM_W, 32: merged immediate width; must be ≥32.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops FIFO contents and pending prefix.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO not full.
- in_instr  in  32  instruction word.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  consumer accepts the record.
- out_op  out  3  opcode, from bits [31:29].
- out_funct  out  4  bits [28:25]; 0 for ops 011, 101, 110 and 111.
- out_immab  out  1  bit [24] for ops 000, 001 and 010; else 0.
- out_imm  out  IMM_W  merged immediate.
- out_has_pfx  out  1  record absorbed a prefix.
- out_offset  out  10  bits [9:0] for op 010; else 0.
- out_nalloc  out  7  bits [6:0] for op 101; else 0.
- out_end  out  1  bit [28] for op 101; else 0.
- out_ta1, out_ta2  out  TA_W  bits [13:8] and [5:0], for ops 000, 001 and 011; else 0.
- out_tt1, out_tt2  out  2  bits [15:14] and [7:6], for the same ops; else 0.
- err_pfx  out  1  one-cycle pulse on a prefix error.

## Operation

- **FIFO.** Circular buffer of FIFO_DEPTH words with pointers one bit wider than the index. Write when in_valid && in_ready. in_ready = !full; it does not depend on a same-cycle pop.
- **Decode stage.** Pops the FIFO head when the FIFO is not empty and either the output register is empty or out_ready is high (`pop`).
- **Prefix instruction (op 100).**
  - The popped word is absorbed: pfx_val ← 1 and pfx_hi ← instr[25:0]. No record is emitted.
  - If pfx_val is already 1, err_pfx pulses and pfx_hi is overwritten.
- **Immediate for a non-prefix word.**
  - immlo = instr[23:18].
  - When pfx_val = 1: imm = {pfx_hi, immlo}, zero-extended to IMM_W. out_has_pfx = 1 and pfx_val clears.
  - When pfx_val = 0: imm = immlo sign-extended from bit 5.
  - Ops 101 and 011 carry no immediate. imm = 0 for them. A pending prefix is consumed and err_pfx pulses.
- **Output register.** Loaded on every non-prefix pop. out_valid is set on load and cleared on out_ready with no load in the same cycle. Record fields hold stable while out_valid && !out_ready.
- **Flush.**
  - Clears the FIFO pointers, pfx_val and out_valid in the same cycle.
  - A push arriving in the flush cycle is discarded.
  - Flush overrides a simultaneous pop.
- **Reset.** Pointers = 0, pfx_val = 0, pfx_hi = 0, out_valid = 0, err_pfx = 0, and all record outputs = 0. in_ready = 1 after reset.

## Timing

- **Minimum latency.** A word pushed in cycle N is poppable in N+1. Its record appears on out_valid in N+2.
- **Prefix latency.** A prefix adds one pop cycle and no output cycle.
- **Throughput.** One record per cycle when out_ready is held high and the FIFO is fed continuously. This holds with FIFO_DEPTH ≥ 2.
- **Back-pressure.** Pushes continue until the FIFO is full. in_ready drops in the cycle after the FIFO_DEPTH-th unpopped write.
- **Simultaneous push and pop.**
  - When full, no push is accepted.
  - When empty, the pushed word is not visible to pop in the same cycle, so there is no bypass.
- **Registered outputs.** err_pfx is registered and asserts in the cycle after the offending pop. out_valid is registered.
- **Mid-operation reset.** Asynchronous reset at any point clears everything immediately. No partial record is emitted afterwards.

## Test plan

1. **Plain decode.** Reset, then push 32'b000_0001_0_010101_00_10_101010_11_111100 with out_ready = 1.
   - Two cycles later: op = 0, funct = 1, immab = 0, imm = 0x15, tt1 = 2, ta1 = 42, tt2 = 3, ta2 = 60, has_pfx = 0.
2. **Prefix merge.** Push 32'b100_000_10101010101010101010101010, then 32'b010_0011_0_010101_00000000_1011001110.
   - Exactly one record: op = 2, funct = 3, imm = {26'h2AAAAAA, 6'b010101}, has_pfx = 1, offset = 0x2CE.
3. **Double prefix and no-immediate consumer.**
   - Prefix, prefix, then op 101 word 32'b101_0_000000000000000000000_1110011.
   - Required: err_pfx pulses twice. The single record has nalloc = 0x73, end = 0, imm = 0, has_pfx = 1.
4. **Back-pressure.**
   - Hold out_ready = 0 and push FIFO_DEPTH+2 words. in_ready must be 0 after FIFO_DEPTH+1 accepted words: FIFO_DEPTH buffered plus 1 in the output register.
   - Release out_ready. All accepted words emerge in order, with no loss or duplication.
5. **Flush.**
   - With 3 words buffered and a prefix pending, assert flush for one cycle.
   - Next cycle: out_valid = 0 and in_ready = 1. The next pushed op-001 word shows has_pfx = 0.
6. **Async reset mid-stream.**
   - Drop rst_n between clock edges during a full, stalled state.
   - Outputs are 0 and in_ready = 1 before the next edge. After release, decode resumes cleanly.
